// File: rtl/trap_unit.sv
// trap_unit: machine-mode trap CSRs, trap entry / MRET sequencing and PC redirect.
// Optional feature macro: TRAP_MTVAL_EN adds the mtval CSR at 0x343 and its
// capture on trap entry. Without it, 0x343 reads 0 and writes are ignored.
module trap_unit #(
  parameter int              XLEN        = 32,
  parameter logic [XLEN-1:0] RESET_MTVEC = 32'h0000_0100
) (
  input  logic            I_clk,
  input  logic            I_rst_n,
  input  logic            I_valid,
  input  logic [XLEN-1:0] I_pc,
  input  logic [31:0]     I_inst,
  input  logic            I_ecall,
  input  logic            I_ebreak,
  input  logic            I_illegalinst,
  input  logic            I_mret,
  input  logic            I_irq,
  input  logic [11:0]     I_csr_addr,
  input  logic            I_csr_wen,
  input  logic [XLEN-1:0] I_csr_wdata,
  output logic [XLEN-1:0] O_csr_rdata,
  output logic            O_kill,
  output logic            O_stall,
  output logic            O_redirect,
  output logic [XLEN-1:0] O_redirect_pc
);

  localparam logic [11:0] ADDR_MSTATUS  = 12'h300;
  localparam logic [11:0] ADDR_MIE      = 12'h304;
  localparam logic [11:0] ADDR_MTVEC    = 12'h305;
  localparam logic [11:0] ADDR_MSCRATCH = 12'h340;
  localparam logic [11:0] ADDR_MEPC     = 12'h341;
  localparam logic [11:0] ADDR_MCAUSE   = 12'h342;
  localparam logic [11:0] ADDR_MTVAL    = 12'h343;
  localparam logic [11:0] ADDR_MIP      = 12'h344;

  localparam logic [XLEN-1:0] CAUSE_ILLEGAL = XLEN'(2);
  localparam logic [XLEN-1:0] CAUSE_EBREAK  = XLEN'(3);
  localparam logic [XLEN-1:0] CAUSE_ECALL   = XLEN'(11);
  localparam logic [XLEN-1:0] CAUSE_MEI     = {1'b1, {(XLEN-5){1'b0}}, 4'd11};

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ENTER  = 2'd1,
    ST_RETURN = 2'd2
  } state_e;

  state_e state_q, state_d;

  // CSR state; mtvec and mepc keep only the word-aligned bits
  logic            mstatus_mie_q,  mstatus_mie_d;
  logic            mstatus_mpie_q, mstatus_mpie_d;
  logic            mie_meie_q,     mie_meie_d;
  logic [XLEN-3:0] mtvec_q,        mtvec_d;
  logic [XLEN-1:0] mscratch_q,     mscratch_d;
  logic [XLEN-3:0] mepc_q,         mepc_d;
  logic [XLEN-1:0] mcause_q,       mcause_d;
`ifdef TRAP_MTVAL_EN
  logic [XLEN-1:0] mtval_q,        mtval_d;
`endif

  logic            sample;
  logic            irq_take;
  logic            trap_take;
  logic            mret_take;
  logic            csr_we;
  logic [XLEN-1:0] trap_cause;
  logic            unused_bits;

  // Low PC bits are always zero for aligned instructions; the raw word only feeds mtval
  assign unused_bits = ^{I_pc[1:0], I_inst};

  // Event decode: only a valid instruction seen while idle can start a sequence
  always_comb begin
    sample     = I_valid && (state_q == ST_IDLE);
    irq_take   = I_irq && mstatus_mie_q && mie_meie_q;
    trap_take  = sample && (I_illegalinst || I_ebreak || I_ecall || irq_take);
    mret_take  = sample && I_mret && !trap_take;
    csr_we     = sample && I_csr_wen && !trap_take && !mret_take;
    trap_cause = CAUSE_MEI;
    if (I_illegalinst) begin
      trap_cause = CAUSE_ILLEGAL;
    end else if (I_ebreak) begin
      trap_cause = CAUSE_EBREAK;
    end else if (I_ecall) begin
      trap_cause = CAUSE_ECALL;
    end
  end

  // FSM next state and pipeline control outputs
  always_comb begin
    state_d       = state_q;
    O_kill        = 1'b0;
    O_stall       = 1'b0;
    O_redirect    = 1'b0;
    O_redirect_pc = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (trap_take) begin
          O_kill  = 1'b1;
          O_stall = 1'b1;
          state_d = ST_ENTER;
        end else if (mret_take) begin
          O_kill  = 1'b1;
          O_stall = 1'b1;
          state_d = ST_RETURN;
        end
      end
      ST_ENTER: begin
        O_redirect    = 1'b1;
        O_stall       = 1'b1;
        O_redirect_pc = {mtvec_q, 2'b00};
        state_d       = ST_IDLE;
      end
      ST_RETURN: begin
        O_redirect    = 1'b1;
        O_stall       = 1'b1;
        O_redirect_pc = {mepc_q, 2'b00};
        state_d       = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // CSR next state: software writes first, trap entry / MRET override them
  always_comb begin
    mstatus_mie_d  = mstatus_mie_q;
    mstatus_mpie_d = mstatus_mpie_q;
    mie_meie_d     = mie_meie_q;
    mtvec_d        = mtvec_q;
    mscratch_d     = mscratch_q;
    mepc_d         = mepc_q;
    mcause_d       = mcause_q;
`ifdef TRAP_MTVAL_EN
    mtval_d        = mtval_q;
`endif
    if (csr_we) begin
      case (I_csr_addr)
        ADDR_MSTATUS: begin
          mstatus_mie_d  = I_csr_wdata[3];
          mstatus_mpie_d = I_csr_wdata[7];
        end
        ADDR_MIE:      mie_meie_d = I_csr_wdata[11];
        ADDR_MTVEC:    mtvec_d    = I_csr_wdata[XLEN-1:2];
        ADDR_MSCRATCH: mscratch_d = I_csr_wdata;
        ADDR_MEPC:     mepc_d     = I_csr_wdata[XLEN-1:2];
        ADDR_MCAUSE:   mcause_d   = I_csr_wdata;
`ifdef TRAP_MTVAL_EN
        ADDR_MTVAL:    mtval_d    = I_csr_wdata;
`endif
        default: ;
      endcase
    end
    if (trap_take) begin
      mepc_d         = I_pc[XLEN-1:2];
      mcause_d       = trap_cause;
      mstatus_mpie_d = mstatus_mie_q;
      mstatus_mie_d  = 1'b0;
`ifdef TRAP_MTVAL_EN
      if (I_illegalinst) begin
        mtval_d = XLEN'(I_inst);
      end else if (I_ebreak) begin
        mtval_d = I_pc;
      end else begin
        mtval_d = '0;
      end
`endif
    end else if (mret_take) begin
      mstatus_mie_d  = mstatus_mpie_q;
      mstatus_mpie_d = 1'b1;
    end
  end

  // CSR read port, combinational from the address
  always_comb begin
    O_csr_rdata = '0;
    case (I_csr_addr)
      ADDR_MSTATUS: begin
        O_csr_rdata[3] = mstatus_mie_q;
        O_csr_rdata[7] = mstatus_mpie_q;
      end
      ADDR_MIE:      O_csr_rdata[11] = mie_meie_q;
      ADDR_MTVEC:    O_csr_rdata     = {mtvec_q, 2'b00};
      ADDR_MSCRATCH: O_csr_rdata     = mscratch_q;
      ADDR_MEPC:     O_csr_rdata     = {mepc_q, 2'b00};
      ADDR_MCAUSE:   O_csr_rdata     = mcause_q;
`ifdef TRAP_MTVAL_EN
      ADDR_MTVAL:    O_csr_rdata     = mtval_q;
`endif
      ADDR_MIP:      O_csr_rdata[11] = I_irq;
      default:       O_csr_rdata     = '0;
    endcase
  end

  // State and CSR registers; reset drops any in-flight redirect
  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      state_q        <= ST_IDLE;
      mstatus_mie_q  <= 1'b0;
      mstatus_mpie_q <= 1'b0;
      mie_meie_q     <= 1'b0;
      mtvec_q        <= RESET_MTVEC[XLEN-1:2];
      mscratch_q     <= '0;
      mepc_q         <= '0;
      mcause_q       <= '0;
`ifdef TRAP_MTVAL_EN
      mtval_q        <= '0;
`endif
    end else begin
      state_q        <= state_d;
      mstatus_mie_q  <= mstatus_mie_d;
      mstatus_mpie_q <= mstatus_mpie_d;
      mie_meie_q     <= mie_meie_d;
      mtvec_q        <= mtvec_d;
      mscratch_q     <= mscratch_d;
      mepc_q         <= mepc_d;
      mcause_q       <= mcause_d;
`ifdef TRAP_MTVAL_EN
      mtval_q        <= mtval_d;
`endif
    end
  end

endmodule

// File: tb/tb_trap_unit.sv
// Directed bench for trap_unit: CSR read/write table plus trap, interrupt,
// MRET and mid-sequence reset scenarios.
module tb_trap_unit;

  logic        clk;
  logic        rst_n;
  logic        valid;
  logic [31:0] pc;
  logic [31:0] inst;
  logic        ecall;
  logic        ebreak;
  logic        illegal;
  logic        mret;
  logic        irq;
  logic [11:0] csr_addr;
  logic        csr_wen;
  logic [31:0] csr_wdata;
  logic [31:0] csr_rdata;
  logic        kill;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [11:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp;
    string       name;
  } csr_vec_t;

  csr_vec_t vecs[11];

  trap_unit #(.XLEN(32), .RESET_MTVEC(32'h0000_0100)) dut (
    .I_clk         (clk),
    .I_rst_n       (rst_n),
    .I_valid       (valid),
    .I_pc          (pc),
    .I_inst        (inst),
    .I_ecall       (ecall),
    .I_ebreak      (ebreak),
    .I_illegalinst (illegal),
    .I_mret        (mret),
    .I_irq         (irq),
    .I_csr_addr    (csr_addr),
    .I_csr_wen     (csr_wen),
    .I_csr_wdata   (csr_wdata),
    .O_csr_rdata   (csr_rdata),
    .O_kill        (kill),
    .O_stall       (stall),
    .O_redirect    (redirect),
    .O_redirect_pc (redirect_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    valid     = 1'b0;
    ecall     = 1'b0;
    ebreak    = 1'b0;
    illegal   = 1'b0;
    mret      = 1'b0;
    csr_wen   = 1'b0;
    csr_wdata = '0;
    pc        = '0;
    inst      = '0;
  endtask

  task automatic write_csr(input logic [11:0] addr, input logic [31:0] data);
    @(negedge clk);
    valid     = 1'b1;
    csr_wen   = 1'b1;
    csr_addr  = addr;
    csr_wdata = data;
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic read_csr(input string name, input logic [11:0] addr, input logic [31:0] exp);
    @(negedge clk);
    idle_inputs();
    csr_addr = addr;
    #1;
    check(name, csr_rdata, exp);
  endtask

  // Cycle T: inputs already driven at a negedge; checks T, then T+1, then T+2
  task automatic expect_sequence(input string name, input logic [31:0] target);
    #1;
    check({name, "_T_kill"}, 32'(kill), 32'd1);
    check({name, "_T_stall"}, 32'(stall), 32'd1);
    check({name, "_T_redirect"}, 32'(redirect), 32'd0);
    @(negedge clk);
    idle_inputs();
    irq = 1'b0;
    #1;
    check({name, "_T1_redirect"}, 32'(redirect), 32'd1);
    check({name, "_T1_pc"}, redirect_pc, target);
    check({name, "_T1_stall"}, 32'(stall), 32'd1);
    check({name, "_T1_kill"}, 32'(kill), 32'd0);
    @(negedge clk);
    #1;
    check({name, "_T2_redirect"}, 32'(redirect), 32'd0);
    check({name, "_T2_stall"}, 32'(stall), 32'd0);
  endtask

  initial begin
    vecs[0]  = '{12'h300, 32'hFFFF_FFFF, 32'h0000_0088, "mstatus_mask"};
    vecs[1]  = '{12'h304, 32'hFFFF_FFFF, 32'h0000_0800, "mie_mask"};
    vecs[2]  = '{12'h305, 32'h0000_0203, 32'h0000_0200, "mtvec_align"};
    vecs[3]  = '{12'h340, 32'hDEAD_BEEF, 32'hDEAD_BEEF, "mscratch"};
    vecs[4]  = '{12'h341, 32'h0000_0107, 32'h0000_0104, "mepc_align"};
    vecs[5]  = '{12'h342, 32'h0000_0005, 32'h0000_0005, "mcause_wr"};
    vecs[6]  = '{12'h344, 32'hFFFF_FFFF, 32'h0000_0000, "mip_ro"};
    vecs[7]  = '{12'h123, 32'hFFFF_FFFF, 32'h0000_0000, "unimpl"};
`ifdef TRAP_MTVAL_EN
    vecs[8]  = '{12'h343, 32'h0000_0055, 32'h0000_0055, "mtval_wr"};
`else
    vecs[8]  = '{12'h343, 32'h0000_0055, 32'h0000_0000, "mtval_absent"};
`endif
    vecs[9]  = '{12'h300, 32'h0000_0000, 32'h0000_0000, "mstatus_clr"};
    vecs[10] = '{12'h304, 32'h0000_0000, 32'h0000_0000, "mie_clr"};

    rst_n    = 1'b0;
    irq      = 1'b0;
    csr_addr = 12'h305;
    idle_inputs();
    repeat (3) @(negedge clk);
    #1;
    check("rst_kill", 32'(kill), 32'd0);
    check("rst_stall", 32'(stall), 32'd0);
    check("rst_redirect", 32'(redirect), 32'd0);
    check("rst_redirect_pc", redirect_pc, 32'd0);
    check("rst_mtvec", csr_rdata, 32'h0000_0100);
    @(negedge clk);
    rst_n = 1'b1;
    read_csr("rst_mstatus", 12'h300, 32'h0);
    read_csr("rst_mepc", 12'h341, 32'h0);

    // ECALL from reset mtvec
    @(negedge clk);
    valid = 1'b1; pc = 32'h40; ecall = 1'b1;
    expect_sequence("ecall", 32'h0000_0100);
    read_csr("ecall_mepc", 12'h341, 32'h40);
    read_csr("ecall_mcause", 12'h342, 32'd11);

    // CSR write/read table
    for (int i = 0; i < 11; i++) begin
      write_csr(vecs[i].addr, vecs[i].wdata);
      read_csr(vecs[i].name, vecs[i].addr, vecs[i].exp);
    end

    // Illegal beats ecall; handler base now 0x200
    @(negedge clk);
    valid = 1'b1; pc = 32'h80; inst = 32'hFFFF_FFFF; illegal = 1'b1; ecall = 1'b1;
    expect_sequence("illegal", 32'h0000_0200);
    read_csr("illegal_mcause", 12'h342, 32'd2);
    read_csr("illegal_mepc", 12'h341, 32'h80);
`ifdef TRAP_MTVAL_EN
    read_csr("illegal_mtval", 12'h343, 32'hFFFF_FFFF);
`endif

    // EBREAK with a simultaneous mepc write: the write is dropped
    @(negedge clk);
    valid = 1'b1; pc = 32'h30; ebreak = 1'b1;
    csr_wen = 1'b1; csr_addr = 12'h341; csr_wdata = 32'h999;
    expect_sequence("ebreak", 32'h0000_0200);
    read_csr("ebreak_mepc", 12'h341, 32'h30);
    read_csr("ebreak_mcause", 12'h342, 32'd3);
`ifdef TRAP_MTVAL_EN
    read_csr("ebreak_mtval", 12'h343, 32'h30);
`endif

    // Enabled external interrupt; irq drops during ENTER
    write_csr(12'h300, 32'h8);
    write_csr(12'h304, 32'h800);
    @(negedge clk);
    valid = 1'b1; pc = 32'h24; irq = 1'b1;
    expect_sequence("irq", 32'h0000_0200);
    read_csr("irq_mcause", 12'h342, 32'h8000_000B);
    read_csr("irq_mepc", 12'h341, 32'h24);
    read_csr("irq_mstatus", 12'h300, 32'h80);
`ifdef TRAP_MTVAL_EN
    read_csr("irq_mtval", 12'h343, 32'h0);
`endif

    // Interrupt pending with MIE=0 is not taken
    @(negedge clk);
    valid = 1'b1; pc = 32'h50; irq = 1'b1;
    #1;
    check("irq_masked_kill", 32'(kill), 32'd0);
    check("irq_masked_stall", 32'(stall), 32'd0);
    @(negedge clk);
    valid = 1'b0;
    csr_addr = 12'h344;
    #1;
    check("irq_masked_redirect", 32'(redirect), 32'd0);
    check("mip_pending", csr_rdata, 32'h800);
    irq = 1'b0;

    // MRET back to mepc, MIE restored
    @(negedge clk);
    valid = 1'b1; pc = 32'h210; mret = 1'b1;
    expect_sequence("mret", 32'h24);
    read_csr("mret_mstatus", 12'h300, 32'h88);

    // Interrupt outranks MRET
    @(negedge clk);
    valid = 1'b1; pc = 32'h60; mret = 1'b1; irq = 1'b1;
    expect_sequence("irq_vs_mret", 32'h0000_0200);
    read_csr("irqmret_mcause", 12'h342, 32'h8000_000B);
    read_csr("irqmret_mepc", 12'h341, 32'h60);
    read_csr("irqmret_mstatus", 12'h300, 32'h80);

    // Asynchronous reset while in ENTER
    @(negedge clk);
    valid = 1'b1; pc = 32'h44; ecall = 1'b1;
    @(negedge clk);
    idle_inputs();
    #1;
    check("rst_enter_pre", 32'(redirect), 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    check("rst_enter_redirect", 32'(redirect), 32'd0);
    check("rst_enter_stall", 32'(stall), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    read_csr("rst_enter_mtvec", 12'h305, 32'h100);
    read_csr("rst_enter_mepc", 12'h341, 32'h0);
    #1;
    check("rst_enter_idle_stall", 32'(stall), 32'd0);
    check("rst_enter_idle_redir", 32'(redirect), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
